// File: rtl/echo_stream.sv
// echo_stream: valid/ready byte loopback through a DEPTH-entry FIFO, with
// optional CR -> CR LF expansion, a TX transfer counter and a sticky done flag.
module echo_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CRLF  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_rx_valid,
  input  logic [WIDTH-1:0] i_rx_data,
  input  logic             i_rx_eof,
  output logic             o_rx_ready,
  output logic             o_tx_valid,
  output logic [WIDTH-1:0] o_tx_data,
  input  logic             i_tx_ready,
  output logic [15:0]      o_count,
  output logic             o_done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [0:0] ST_PASS = 1'b0;
  localparam logic [0:0] ST_LF   = 1'b1;
  localparam logic [WIDTH-1:0] CR_C = WIDTH'(8'h0D);
  localparam logic [WIDTH-1:0] LF_C = WIDTH'(8'h0A);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic CRLF_EN = (CRLF != 0);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [0:0]       state_r;
  logic             eof_seen_r;
  logic             done_r;
  logic [15:0]      count_r;

  logic             empty_s;
  logic             full_s;
  logic             rx_xfer_s;
  logic             wr_en_s;
  logic             tx_xfer_s;
  logic             is_cr_s;
  logic [WIDTH-1:0] head_s;

  // FIFO status, handshakes and the output mux selected by the LF state
  always_comb begin
    empty_s    = (wr_ptr_r == rd_ptr_r);
    full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                 (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    o_rx_ready = !rst && !full_s && !eof_seen_r;
    rx_xfer_s  = i_rx_valid && o_rx_ready;
    wr_en_s    = rx_xfer_s && !i_rx_eof;
    head_s     = mem_r[rd_ptr_r[AW-1:0]];
    o_tx_valid = 1'b0;
    o_tx_data  = head_s;
    case (state_r)
      ST_PASS: begin
        o_tx_valid = !empty_s && !done_r;
        o_tx_data  = head_s;
      end
      ST_LF: begin
        o_tx_valid = 1'b1;
        o_tx_data  = LF_C;
      end
      default: begin
        o_tx_valid = 1'b0;
        o_tx_data  = head_s;
      end
    endcase
    tx_xfer_s = o_tx_valid && i_tx_ready;
    is_cr_s   = CRLF_EN && (state_r == ST_PASS) && (o_tx_data == CR_C);
  end

  // storage array; no reset needed since pointers define what is valid
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= i_rx_data;
    end
  end

  // pointers, EOF/done tracking, transfer counter and the LF-injection state
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      state_r    <= ST_PASS;
      eof_seen_r <= 1'b0;
      done_r     <= 1'b0;
      count_r    <= 16'd0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rx_xfer_s && i_rx_eof) begin
        eof_seen_r <= 1'b1;
      end
      if (tx_xfer_s) begin
        count_r <= count_r + 16'd1;
      end
      if (tx_xfer_s && (state_r == ST_PASS)) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (eof_seen_r && empty_s && (state_r == ST_PASS)) begin
        done_r <= 1'b1;
      end
      case (state_r)
        ST_PASS: state_r <= (tx_xfer_s && is_cr_s) ? ST_LF : ST_PASS;
        ST_LF:   state_r <= tx_xfer_s ? ST_PASS : ST_LF;
        default: state_r <= ST_PASS;
      endcase
    end
  end

  assign o_count = count_r;
  assign o_done  = done_r;

endmodule

// File: tb/tb_echo_stream.sv
// Scoreboard bench for echo_stream: dut_a has CRLF=0, dut_b has CRLF=1; they
// share data/eof/tx_ready and are offered input through separate valids.
module tb_echo_stream;

  localparam int TO = 500;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid [2];
  logic [7:0]  rx_data;
  logic        rx_eof;
  logic        tx_ready;
  logic        rx_ready [2];
  logic        tx_valid [2];
  logic [7:0]  tx_data  [2];
  logic [15:0] count    [2];
  logic        done     [2];

  logic [7:0]  exp_q [2][$];
  logic [15:0] pushed [2];
  logic        prev_stall [2];
  logic [7:0]  prev_data  [2];
  logic        rnd_tx;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  echo_stream #(.WIDTH(8), .DEPTH(16), .CRLF(0)) dut_a (
    .clk(clk), .rst(rst), .i_rx_valid(rx_valid[0]), .i_rx_data(rx_data),
    .i_rx_eof(rx_eof), .o_rx_ready(rx_ready[0]), .o_tx_valid(tx_valid[0]),
    .o_tx_data(tx_data[0]), .i_tx_ready(tx_ready), .o_count(count[0]),
    .o_done(done[0])
  );

  echo_stream #(.WIDTH(8), .DEPTH(16), .CRLF(1)) dut_b (
    .clk(clk), .rst(rst), .i_rx_valid(rx_valid[1]), .i_rx_data(rx_data),
    .i_rx_eof(rx_eof), .o_rx_ready(rx_ready[1]), .o_tx_valid(tx_valid[1]),
    .o_tx_data(tx_data[1]), .i_tx_ready(tx_ready), .o_count(count[1]),
    .o_done(done[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic push_exp(input int k, input logic [7:0] d);
    exp_q[k].push_back(d);
    pushed[k] = pushed[k] + 16'd1;
    if (k == 1 && d == 8'h0D) begin
      exp_q[k].push_back(8'h0A);
      pushed[k] = pushed[k] + 16'd1;
    end
  endtask

  // Offer one beat to DUT k; returns just after the accepting edge, valid left high for data.
  task automatic send(input int k, input logic [7:0] d, input logic eof);
    int t = 0;
    logic ok = 1'b1;
    rx_valid[k] = 1'b1;
    rx_data     = d;
    rx_eof      = eof;
    forever begin
      @(negedge clk);
      if (rx_ready[k]) break;
      t++;
      if (t > TO) begin
        check("rx_accept_timeout", 32'd0, 32'd1);
        ok = 1'b0;
        break;
      end
    end
    if (ok && !eof) push_exp(k, d);
    @(posedge clk); #1;
    rx_eof = 1'b0;
    if (eof || !ok) rx_valid[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    int t = 0;
    while (exp_q[k].size() != 0 && t < TO * 4) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", 32'(exp_q[k].size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst         = 1'b1;
    rx_valid[0] = 1'b0;
    rx_valid[1] = 1'b0;
    rx_eof      = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_q[k].delete();
      pushed[k] = 16'd0;
    end
    #2;
    for (int k = 0; k < 2; k++) check("rx_ready_in_reset", 32'(rx_ready[k]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("reset_tx_valid", 32'(tx_valid[k]), 32'd0);
      check("reset_count", 32'(count[k]), 32'd0);
      check("reset_done", 32'(done[k]), 32'd0);
      check("rx_ready_after_reset", 32'(rx_ready[k]), 32'd1);
    end
  endtask

  // Randomised sink readiness, changed only at the clock edge.
  always @(posedge clk) begin
    if (rnd_tx) tx_ready <= 1'($urandom_range(0, 1));
  end

  // Monitor: pops the scoreboard on every TX transfer and checks stall stability.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        prev_stall[k] <= 1'b0;
      end else begin
        if (prev_stall[k]) begin
          check("hold_valid", 32'(tx_valid[k]), 32'd1);
          check("hold_data", 32'(tx_data[k]), 32'(prev_data[k]));
        end
        if (tx_valid[k] && tx_ready) begin
          if (exp_q[k].size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_tx dut%0d: got 0x%0h, required no output", k, tx_data[k]);
          end else begin
            check($sformatf("tx_data_dut%0d", k), 32'(tx_data[k]), 32'(exp_q[k].pop_front()));
          end
        end
        prev_stall[k] <= tx_valid[k] && !tx_ready;
        prev_data[k]  <= tx_data[k];
      end
    end
  end

  initial begin
    rst = 1'b1; rx_valid[0] = 1'b0; rx_valid[1] = 1'b0;
    rx_data = 8'h00; rx_eof = 1'b0; tx_ready = 1'b0; rnd_tx = 1'b0;
    pushed[0] = 16'd0; pushed[1] = 16'd0;

    // basic echo with one-cycle latency
    do_reset();
    tx_ready = 1'b1;
    send(0, 8'h41, 1'b0);
    #1;
    check("latency_valid", 32'(tx_valid[0]), 32'd1);
    check("latency_data", 32'(tx_data[0]), 32'h41);
    send(0, 8'h42, 1'b0);
    send(0, 8'h43, 1'b0);
    rx_valid[0] = 1'b0;
    drain(0);
    check("basic_count", 32'(count[0]), 32'd3);

    // full FIFO blocks input, then push and pop together
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(0, 8'(8'h80 + i), 1'b0);
    rx_data = 8'h90;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_rx_ready", 32'(rx_ready[0]), 32'd0);
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    for (int i = 16; i < 20; i++) send(0, 8'(8'h80 + i), 1'b0);
    rx_valid[0] = 1'b0;
    drain(0);
    check("full_count", 32'(count[0]), 32'd20);

    // CR expansion with a randomly stalling sink; CRLF=0 passes CR alone
    do_reset();
    rnd_tx = 1'b1;
    send(1, 8'h68, 1'b0);
    send(1, 8'h0D, 1'b0);
    send(1, 8'h69, 1'b0);
    rx_valid[1] = 1'b0;
    drain(1);
    rnd_tx = 1'b0;
    @(posedge clk); #2;
    check("crlf_count", 32'(count[1]), 32'd4);
    tx_ready = 1'b1;
    send(0, 8'h0D, 1'b0);
    rx_valid[0] = 1'b0;
    drain(0);
    check("no_crlf_count", 32'(count[0]), 32'd1);

    // EOF behind a buffered byte
    do_reset();
    tx_ready = 1'b0;
    send(0, 8'h31, 1'b0);
    send(0, 8'h00, 1'b1);
    check("eof_rx_ready", 32'(rx_ready[0]), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("eof_rx_ready_hold", 32'(rx_ready[0]), 32'd0);
    check("eof_done_early", 32'(done[0]), 32'd0);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    check("done_at_last_tx", 32'(done[0]), 32'd0);
    @(posedge clk); #1;
    check("done_after_last_tx", 32'(done[0]), 32'd1);
    check("eof_count", 32'(count[0]), 32'd1);
    rx_valid[0] = 1'b1; rx_data = 8'h99;
    @(posedge clk); #1;
    rx_valid[0] = 1'b0;
    check("done_sticky", 32'(done[0]), 32'd1);
    check("done_tx_valid", 32'(tx_valid[0]), 32'd0);
    check("done_rx_ready", 32'(rx_ready[0]), 32'd0);

    // EOF on an empty FIFO
    do_reset();
    send(0, 8'h00, 1'b1);
    check("empty_eof_done_early", 32'(done[0]), 32'd0);
    @(posedge clk); #1;
    check("empty_eof_done", 32'(done[0]), 32'd1);

    // reset while an LF is pending and bytes are buffered
    do_reset();
    tx_ready = 1'b0;
    send(1, 8'h0D, 1'b0);
    for (int i = 0; i < 7; i++) send(1, 8'(8'h50 + i), 1'b0);
    rx_valid[1] = 1'b0;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    #1;
    check("lf_pending_valid", 32'(tx_valid[1]), 32'd1);
    check("lf_pending_data", 32'(tx_data[1]), 32'h0A);
    do_reset();
    tx_ready = 1'b1;
    send(1, 8'h77, 1'b0);
    rx_valid[1] = 1'b0;
    drain(1);
    check("post_reset_count", 32'(count[1]), 32'd1);

    // long stream: random ready both sides, then full rate past the counter wrap
    do_reset();
    rnd_tx = 1'b1;
    for (int i = 0; i < 66000; i++) begin
      if (i == 1500) begin
        rnd_tx = 1'b0;
        @(posedge clk); #1;
        tx_ready = 1'b1;
      end
      if (i < 1500 && $urandom_range(0, 3) == 0) begin
        rx_valid[0] = 1'b0;
        @(posedge clk); #1;
      end
      send(0, 8'(i) ^ 8'hA5, 1'b0);
    end
    rx_valid[0] = 1'b0;
    drain(0);
    check("wrap_count", 32'(count[0]), 32'd464);
    check("wrap_count_model", 32'(count[0]), 32'(pushed[0]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/echo_stream.md
# echo_stream

Synthesizable, parametrised successor to the simulation-only character echo: accepts a byte stream on a valid/ready input, buffers it in a DEPTH-entry FIFO, and replays it on a valid/ready output. Optionally expands CR to CR LF. Tracks end-of-input and transmitted-byte count. Sits between a UART/USB RX byte source and the matching TX sink on the Fomu, and serves as the loopback block for link bring-up.

## Interface
- WIDTH, 8: data width in bits; must be ≥ 8 when CRLF=1.
- DEPTH, 16: FIFO entries; power of two, ≥ 2.
- CRLF, 0: 1 = inject LF (0x0A) after every transmitted CR (0x0D).
- clk  input  1  single system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- i_rx_valid  input  1  source offers `i_rx_data` / `i_rx_eof`.
- i_rx_data  input  WIDTH  byte offered.
- i_rx_eof  input  1  offer is an end-of-input marker (data ignored), qualified by `i_rx_valid`.
- o_rx_ready  output  1  block accepts the offer this cycle.
- o_tx_valid  output  1  `o_tx_data` is valid.
- o_tx_data  output  WIDTH  byte to sink.
- i_tx_ready  input  1  sink accepts this cycle.
- o_count  output  16  TX transfers completed, including injected LFs.
- o_done  output  1  EOF received and all buffered output drained; sticky.

## Operation
- RX transfer: `i_rx_valid & o_rx_ready` at a posedge.
  - `i_rx_eof=0`: write `i_rx_data` at `wr_ptr`, advance.
  - `i_rx_eof=1`: set `eof_seen`; nothing written.
- `o_rx_ready = !rst & !full & !eof_seen`.
  - Full blocks input even if a pop occurs the same cycle; no bypass.
- Pointers are log2(DEPTH)+1 bits, wrapping naturally.
  - empty when pointers are equal.
  - full when the MSBs differ and the remaining bits are equal.
- TX transfer: `o_tx_valid & i_tx_ready` at a posedge; increments `o_count` (mod 2^16).
- Output FSM, 2 states:
  - PASS:
    - `o_tx_valid = !empty`; `o_tx_data = mem[rd_ptr]` (combinational read).
    - On a TX transfer, advance `rd_ptr`.
    - If CRLF=1 and the transferred data == 0x0D, go to LF.
  - LF:
    - `o_tx_valid = 1`; `o_tx_data = 0x0A` (zero-extended to WIDTH).
    - FIFO not read.
    - On a TX transfer, return to PASS.
- With CRLF=0 the FSM never leaves PASS.
- A received LF is passed through unchanged (CR LF input yields CR LF LF).
- `o_done` sets at the posedge where `eof_seen & empty & state==PASS` holds. It holds until reset. Once done, `o_tx_valid=0`.
- Simultaneous RX and TX transfers in one cycle are both performed; occupancy is unchanged.

## Timing
- Reset values (the cycle after `rst` sampled high):
  - pointers 0; state PASS; `eof_seen=0`; `o_count=0`; `o_done=0`.
  - `o_tx_valid=0`; `o_tx_data` don't-care.
  - `o_rx_ready=0` while `rst` is high, 1 on the first cycle after.
- Latency: a byte accepted at posedge N is presented on `o_tx_valid` in cycle N+1.
- Throughput: one byte per cycle each way.
  - An injected LF costs one TX cycle.
  - The FIFO keeps accepting during LF until full.
- Handshake rules:
  - `o_tx_valid`/`o_tx_data` stay stable until transferred.
  - The block never drops valid without a transfer, except by reset.
  - `o_rx_ready` does not depend combinationally on `i_rx_valid`.
- EOF:
  - No RX is accepted from the cycle after the EOF transfer until reset.
  - `o_done` rises the cycle after the last TX transfer (or after the EOF transfer if already empty).
- Mid-operation reset discards the FIFO contents and any pending LF; nothing is emitted afterwards from the discarded data.
- `o_count` wraps 0xFFFF → 0x0000 without a flag.

## Test plan
- Basic echo:
  - Stimulus: DEPTH=16, CRLF=0, `i_tx_ready=1`; send 0x41, 0x42, 0x43 back-to-back.
  - Response: same bytes out, each one cycle after acceptance; `o_count=3`.
- Full/backpressure:
  - Stimulus: `i_tx_ready=0`; offer 20 bytes.
  - Response: 16 accepted, then `o_rx_ready=0`.
  - Then raise `i_tx_ready` with input still offered (push+pop same cycle): all 20 bytes are emitted in order with no loss or duplication.
- CRLF:
  - Stimulus: CRLF=1; send 0x68, 0x0D, 0x69 with random `i_tx_ready`.
  - Response: 0x68, 0x0D, 0x0A, 0x69; `o_count=4`; each held stable while stalled.
- EOF/done:
  - Stimulus: send 0x31, then EOF, with `i_tx_ready=0` for 5 cycles, then 1.
  - Response: `o_rx_ready` low from the EOF onward; `o_done` rises the cycle after 0x31 transfers.
  - Also: EOF on an empty FIFO sets `o_done` the next cycle.
- Reset mid-stream:
  - Stimulus: 8 bytes buffered with CR pending LF (CRLF=1); pulse `rst` for 1 cycle.
  - Response: `o_tx_valid=0`, `o_count=0`, `o_done=0`; the next byte is echoed normally.
- Wrap:
  - Stimulus: stream 70000 bytes with random ready on both sides.
  - Response: scoreboard match; `o_count = 70000 mod 65536 = 4464`.
